// File: rtl/reciprocal_nr.sv
// Iterative Newton-Raphson reciprocal of a signed fixed-point operand.
// The operand magnitude is normalised into [0.5,1) using a leading-zero
// count, a linear seed is refined ITERS times in unsigned Q2.16, and the
// estimate is shifted back into the operand format with saturation.

// Leading-zero counter; an all-zero input reports Width.
module lzc #(
  parameter int unsigned Width = 18,
  parameter int unsigned CntW  = $clog2(Width + 1)
) (
  input  logic [Width-1:0] data_i,
  output logic [CntW-1:0]  cnt_o
);

  // Scan LSB to MSB so the highest set bit has the final say.
  always_comb begin
    cnt_o = CntW'(Width);
    for (int i = 0; i < Width; i++) begin
      if (data_i[i]) cnt_o = CntW'(Width - 1 - i);
    end
  end

endmodule

module reciprocal_nr #(
  parameter int unsigned QM    = 9,
  parameter int unsigned QN    = 10,
  parameter int unsigned ITERS = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [QM+QN-1:0] i_data,
  output logic             busy,
  output logic             done,
  output logic [QM+QN-1:0] o_data,
  output logic             o_sat,
  output logic             o_div0
);

  localparam int unsigned W     = QM + QN;
  localparam int unsigned MagW  = W - 1;                 // unsigned magnitude / Q0.MagW mantissa
  localparam int unsigned LzW   = $clog2(MagW + 1);
  localparam int unsigned XW    = 18;                    // Q2.16 estimate
  localparam int unsigned PW    = MagW + XW;             // full product width
  localparam int unsigned IterW = $clog2(ITERS + 1);
  // Leading-zero count at which the Q2.16 estimate is already in the output format.
  localparam int          Pivot = int'(MagW) + 16 - 2 * int'(QN);
  // Wide enough for the largest left shift (zero operand, lz = MagW).
  localparam int unsigned RW    = XW + MagW - 1 - 13 + 2 * QN - 16;

  // 48/17 and 32/17 in Q2.16 (12-bit-precision constants padded with zeros).
  localparam logic [XW-1:0] SeedOff   = 18'h2D2D0;
  localparam logic [XW-1:0] SeedSlope = 18'h1E1E0;
  localparam logic [XW-1:0] Two       = 18'h20000;

  typedef enum logic [2:0] {
    StIdle,
    StNorm,
    StSeed,
    StItA,
    StItB,
    StDenorm
  } state_e;

  state_e            state_q, state_d;
  logic              sign_q, sign_d;
  logic [MagW-1:0]   mag_q, mag_d;
  logic [LzW-1:0]    lz_q, lz_d;
  logic [MagW-1:0]   m_q, m_d;
  logic              zero_q, zero_d;
  logic [XW-1:0]     x_q, x_d;
  logic [XW-1:0]     t_q, t_d;
  logic [IterW-1:0]  iter_q, iter_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [W-1:0]      data_q, data_d;
  logic              sat_q, sat_d;
  logic              div0_q, div0_d;

  logic [MagW-1:0]   mag_in;
  logic [LzW-1:0]    lz_c;
  logic [MagW-1:0]   m_norm;
  logic [XW-1:0]     seed_term;
  logic [XW-1:0]     x_seed;
  logic [XW-1:0]     mx_term;
  logic [XW-1:0]     t_next;
  logic [XW-1:0]     x_next;
  logic [RW-1:0]     r_wide;
  logic              res_sat;
  logic [MagW-1:0]   res_mag;
  logic [W-1:0]      res_data;

  lzc #(
    .Width (MagW),
    .CntW  (LzW)
  ) u_lzc (
    .data_i (mag_q),
    .cnt_o  (lz_c)
  );

  // Operand magnitude; the most negative code has no positive twin and clips to all-ones.
  always_comb begin
    if (!i_data[W-1]) begin
      mag_in = i_data[MagW-1:0];
    end else if (i_data[MagW-1:0] == '0) begin
      mag_in = '1;
    end else begin
      mag_in = MagW'(W'(0) - i_data);
    end
  end

  // Arithmetic for each state; every product is truncated back to Q2.16.
  always_comb begin
    m_norm    = mag_q << lz_c;
    seed_term = XW'((PW'(SeedSlope) * PW'(m_q)) >> MagW);
    x_seed    = SeedOff - seed_term;
    mx_term   = XW'((PW'(m_q) * PW'(x_q)) >> MagW);
    t_next    = (mx_term >= Two) ? '0 : (Two - mx_term);
    x_next    = XW'((PW'(x_q) * PW'(t_q)) >> 16);
  end

  // Undo the normalisation, saturate out-of-range or zero results, reapply the sign.
  always_comb begin
    if (int'(lz_q) >= Pivot) begin
      r_wide = RW'(x_q) << (int'(lz_q) - Pivot);
    end else begin
      r_wide = RW'(x_q) >> (Pivot - int'(lz_q));
    end
    res_sat  = zero_q || (r_wide[RW-1:MagW] != '0) || (r_wide == '0);
    res_mag  = res_sat ? '1 : r_wide[MagW-1:0];
    res_data = sign_q ? (W'(0) - {1'b0, res_mag}) : {1'b0, res_mag};
  end

  // FSM next-state and register updates; every sequence has the same length.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    lz_d    = lz_q;
    m_d     = m_q;
    zero_d  = zero_q;
    x_d     = x_q;
    t_d     = t_q;
    iter_d  = iter_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    data_d  = data_q;
    sat_d   = sat_q;
    div0_d  = div0_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sign_d  = i_data[W-1];
          mag_d   = mag_in;
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = StNorm;
        end
      end
      StNorm: begin
        lz_d    = lz_c;
        m_d     = m_norm;
        zero_d  = (lz_c == LzW'(MagW));
        state_d = StSeed;
      end
      StSeed: begin
        x_d     = x_seed;
        state_d = StItA;
      end
      StItA: begin
        t_d     = t_next;
        state_d = StItB;
      end
      StItB: begin
        x_d    = x_next;
        iter_d = iter_q + 1'b1;
        if (iter_q == IterW'(ITERS - 1)) begin
          state_d = StDenorm;
        end else begin
          state_d = StItA;
        end
      end
      StDenorm: begin
        data_d  = res_data;
        sat_d   = res_sat;
        div0_d  = zero_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sign_q <= 1'b0;
      mag_q  <= '0;
      lz_q   <= '0;
      m_q    <= '0;
      zero_q <= 1'b0;
      x_q    <= '0;
      t_q    <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      data_q <= '0;
      sat_q  <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      sign_q <= sign_d;
      mag_q  <= mag_d;
      lz_q   <= lz_d;
      m_q    <= m_d;
      zero_q <= zero_d;
      x_q    <= x_d;
      t_q    <= t_d;
      iter_q <= iter_d;
      busy_q <= busy_d;
      done_q <= done_d;
      data_q <= data_d;
      sat_q  <= sat_d;
      div0_q <= div0_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign o_data = data_q;
  assign o_sat  = sat_q;
  assign o_div0 = div0_q;

endmodule

// File: tb/tb_reciprocal_nr.sv
// Bench for reciprocal_nr: expected results come from an exact integer
// reciprocal (2^20 / |x|) and are queued per accepted request.
module tb_reciprocal_nr;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [18:0] i_data;
  logic        busy;
  logic        done;
  logic [18:0] o_data;
  logic        o_sat;
  logic        o_div0;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  typedef struct {
    int data;
    int tol;
    bit sat;
    bit div0;
    bit chk_sat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  reciprocal_nr #(
    .QM    (9),
    .QN    (10),
    .ITERS (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .i_data  (i_data),
    .busy    (busy),
    .done    (done),
    .o_data  (o_data),
    .o_sat   (o_sat),
    .o_div0  (o_div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp, input int tol);
    int diff;
    n_tests++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) tol %0d",
               tag, got, got, exp, exp, tol);
    end
  endtask

  // Exact reference: Q9.10 reciprocal of v/1024 is 2^20 / v.
  function automatic exp_t exp_of(input logic [18:0] d);
    exp_t e;
    int   v;
    int   a;
    int   q;
    v = int'($signed(d));
    a = (v < 0) ? -v : v;
    e.tol     = 0;
    e.chk_sat = 1'b1;
    e.div0    = (a == 0);
    if (a == 0) begin
      e.data = 262143;
      e.sat  = 1'b1;
    end else if (a < 4) begin
      e.data = (v < 0) ? -262143 : 262143;
      e.sat  = 1'b1;
    end else if (a == 4) begin
      // Exactly on the saturation boundary: either side is acceptable.
      e.data    = (v < 0) ? -262143 : 262143;
      e.tol     = 1;
      e.sat     = 1'b1;
      e.chk_sat = 1'b0;
    end else begin
      q      = (1 << 20) / a;
      e.data = (v < 0) ? -q : q;
      e.tol  = 1;
      e.sat  = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [18:0] rand_operand();
    int a;
    a = int'($urandom_range(262143, 16));
    return ($urandom_range(1, 0) != 0) ? 19'(-a) : 19'(a);
  endfunction

  // Scoreboard consumer: one queued expectation per done pulse.
  always @(negedge clk) begin
    if (reset_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("done_unexpected", int'(done), 0, 0);
      end else begin
        mon_e = sb.pop_front();
        check("o_data", int'($signed(o_data)), mon_e.data, mon_e.tol);
        if (mon_e.chk_sat) check("o_sat", int'(o_sat), int'(mon_e.sat), 0);
        check("o_div0", int'(o_div0), int'(mon_e.div0), 0);
      end
    end
  end

  // Issue one request from a point just after a rising edge; returns in the done cycle.
  task automatic do_op(input logic [18:0] d);
    int n;
    bit seen;
    start  = 1'b1;
    i_data = d;
    sb.push_back(exp_of(d));
    @(posedge clk);
    #1;
    start  = 1'b0;
    i_data = 19'($urandom);
    check("busy_accept", int'(busy), 1, 0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (i_data != 19'h0) i_data = 19'($urandom);
      if (done) seen = 1'b1;
    end
    check("latency", n, 9, 0);
    check("busy_at_done", int'(busy), 0, 0);
    if (!seen) sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int accepts;
    int d0;
    logic [18:0] v;

    reset_n = 1'b0;
    start   = 1'b0;
    i_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0, 0);
    check("rst_done", int'(done), 0, 0);
    check("rst_o_data", int'(o_data), 0, 0);
    check("rst_o_sat", int'(o_sat), 0, 0);
    check("rst_o_div0", int'(o_div0), 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed values, issued back to back.
    do_op(19'h00400);
    do_op(19'h7F000);
    do_op(19'h00800);
    do_op(19'h00000);
    repeat (5) @(posedge clk);
    #1;
    check("hold_o_data", int'(o_data), 262143, 0);
    check("hold_o_div0", int'(o_div0), 1, 0);
    do_op(19'h00001);
    do_op(19'h3FFFF);
    do_op(19'h40000);
    do_op(19'h00002);
    do_op(19'h7FFFD);
    do_op(19'h00C00);

    for (int i = 0; i < 12; i++) begin
      do_op(rand_operand());
    end
    repeat (3) @(posedge clk);
    #1;

    // start held high with i_data changing every cycle.
    start   = 1'b1;
    gap     = 0;
    accepts = 0;
    d0      = done_cnt;
    for (int c = 0; c < 30; c++) begin
      v      = rand_operand();
      i_data = v;
      @(posedge clk);
      if (gap == 0) begin
        sb.push_back(exp_of(v));
        accepts++;
        gap = 9;
      end else begin
        gap--;
      end
      #1;
    end
    start = 1'b0;
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    #1;
    check("held_sb_empty", sb.size(), 0, 0);
    check("held_done_count", done_cnt - d0, accepts, 0);

    // Reset in the middle of an operation.
    do_op(19'h00000);
    start  = 1'b1;
    i_data = 19'h00C00;
    sb.push_back(exp_of(19'h00C00));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0, 0);
    check("abort_o_data", int'(o_data), 0, 0);
    check("abort_o_sat", int'(o_sat), 0, 0);
    check("abort_o_div0", int'(o_div0), 0, 0);
    sb.delete();
    d0 = done_cnt;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0, 0);
    do_op(19'h00C00);
    repeat (3) @(posedge clk);
    #1;
    check("final_sb_empty", sb.size(), 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reciprocal_nr.md
# reciprocal_nr

Iterative fixed-point reciprocal unit that consumes the leading-zero count of a Q9.10 operand to normalise it. It computes 1/x by Newton-Raphson over a fixed number of cycles and returns a saturated, signed Q9.10 result through a start/done handshake. It sits in the ray-casting datapath wherever a ray direction component or distance must be inverted, for example for delta-distance and wall height. It instantiates the existing `lzc` block on the operand magnitude.

## Interface
- `QM`, 9, integer bits of the Q format, sign included.
- `QN`, 10, fractional bits; the operand/result width W = QM+QN = 19.
- `ITERS`, 3, number of Newton-Raphson iterations (1..4).
- `clk` in 1: the only clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `i_data` in 19: signed Q9.10 operand; captured on the accepting edge.
- `busy` out 1: high from the accepting edge until the done edge.
- `done` out 1: one-cycle pulse when `o_data` becomes valid.
- `o_data` out 19: signed Q9.10 result; held until the next `done`.
- `o_sat` out 1: the result was clipped, or the input was zero; valid with `done`, held.
- `o_div0` out 1: the input was exactly zero; valid with `done`, held.

## Operation
- FSM states: IDLE → NORM → SEED → ITA → ITB, repeated ITERS times → DENORM → IDLE.
- **IDLE:** when `start`=1, latch `sign = i_data[18]` and `mag = |i_data|` (18 bits unsigned). The value -2^18 maps to mag = 2^18-1. Assert `busy`.
- **NORM:**
  - `lz = lzc(mag)`, range 0..18.
  - `m = mag << lz` (18 bits, unsigned Q0.18, in [0.5,1)).
  - If lz=18, the zero flag is set.
- **SEED:** `x = 48/17 - 32/17·m`, computed in unsigned Q2.16. Constants are 0x2D2D and 0x1E1E scaled to Q2.16; the result truncates.
- **ITA:** `t = 2.0 - (m·x)`. The product is truncated to Q2.16 and `t` is clamped at 0.
- **ITB:** `x = (x·t)`, truncated to Q2.16. Increment the iteration counter; go back to ITA until the counter reaches ITERS.
- **DENORM:** `r = x << (lz-14)` if lz ≥ 14, else `x >> (14-lz)` (truncating).
  - If r ≥ 2^18 or zero: r = 2^18-1 and `o_sat`=1.
  - `o_data = sign ? -r : r`. Zero input gives +0x3FFFF with `o_div0`=1 and `o_sat`=1.
  - Register the outputs and pulse `done`; return to IDLE and drop `busy` on the same edge.
- Latency is fixed and data-independent. A zero operand runs the full sequence.
- `start` while busy is ignored; it is neither queued nor an error.
- `i_data` is not required to be stable after the accepting edge.
- Multipliers are 18×18 unsigned and purely combinational within one state.

## Timing
- Reset values: `busy`=0, `done`=0, `o_data`=0, `o_sat`=0, `o_div0`=0. State is IDLE and all internal registers are 0.
- Accepting edge E0: `busy`=1 after E0.
- `done`=1 in the cycle after edge E(3+2·ITERS), which is E9 for the default ITERS=3. `busy`=0 in that same cycle.
- Back-to-back operation: `start` high during the `done` cycle is accepted at the next edge, since the FSM is already in IDLE. Peak throughput is one result per 4+2·ITERS cycles.
- Asserting `reset_n` mid-operation aborts immediately with no `done` pulse. All outputs return to reset values.
- Accuracy for ITERS=3: non-saturated results are within ±1 LSB of the truncated exact 1/x.

## Test plan
- **Basic reciprocal:** reset, then `i_data`=0x00400 (1.0) → `done` at E9, `o_data`=0x00400 ±1 LSB, `o_sat`=0, `o_div0`=0.
- **Sign handling:** `i_data`=0x7F000 (-4.0) → `o_data`=0x7FF00 (-0.25) ±1. Separately, 0x00800 (2.0) → 0x00200.
- **Zero and overflow:**
  - `i_data`=0 → `o_data`=0x3FFFF, `o_div0`=1, `o_sat`=1, latency still 9.
  - `i_data`=0x00001 → 0x3FFFF, `o_sat`=1, `o_div0`=0.
- **Range extremes:**
  - `i_data`=0x3FFFF (~256) → `o_data` in {0x00003, 0x00004}.
  - `i_data`=0x40000 → 0x7FFFC ±1, `o_sat`=0.
- **Handshake:**
  - `start` held high through an operation with `i_data` changing → exactly one `done` per accepted request.
  - Inputs are captured only at the accepting edges.
  - A start in the `done` cycle produces the next `done` 9 cycles later.
- **Reset mid-operation:** pulse `reset_n` low at E4 → `busy`=0 and `o_data`=0 immediately, no `done`. A subsequent request completes normally.
